// File: rtl/rtc_pkg.sv
// rtc_pkg: FSM state codes, RTC register map and init write table shared by
// the access sequencer, the bus-timing engine and the display logic.
package rtc_pkg;

    localparam logic [2:0] S_INIT      = 3'd0;
    localparam logic [2:0] S_INIT_WAIT = 3'd1;
    localparam logic [2:0] S_IDLE      = 3'd2;
    localparam logic [2:0] S_RD        = 3'd3;
    localparam logic [2:0] S_RD_WAIT   = 3'd4;
    localparam logic [2:0] S_WR        = 3'd5;
    localparam logic [2:0] S_WR_WAIT   = 3'd6;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } rtc_wr_t;

    localparam int         INIT_LEN  = 2;
    localparam logic [2:0] INIT_LAST = 3'(INIT_LEN - 1);
    localparam logic [2:0] TIME_LAST = 3'd5;

    // seg, min, hora, dia, mes, anio (element 0 = seg)
    localparam logic [5:0][7:0] TIME_ADDR = {
        8'h26, 8'h25, 8'h24, 8'h23, 8'h22, 8'h21
    };

    // Element 0 sets the init bit, element 1 clears it again.
    localparam rtc_wr_t [INIT_LEN-1:0] INIT_TBL = {
        rtc_wr_t'{addr: 8'h02, data: 8'h00},
        rtc_wr_t'{addr: 8'h02, data: 8'h10}
    };

    function automatic logic is_wait(input logic [2:0] s);
        return (s == S_INIT_WAIT) || (s == S_RD_WAIT) || (s == S_WR_WAIT);
    endfunction

endpackage

// File: rtl/rtc_tick_counter.sv
// rtc_tick_counter: saturating up-counter flagging when it holds LIMIT-1.
// Used for the refresh interval and the bus_listo wait timeout.
module rtc_tick_counter #(
    parameter int unsigned LIMIT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam int unsigned W    = (LIMIT > 2) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign hit = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !hit) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rtc_access_sequencer.sv
// rtc_access_sequencer: init writes, periodic time sweeps and user writes to
// the RTC timing engine. Define RTC_SEQ_TIMEOUT_EN for the bus_listo timeout.
module rtc_access_sequencer
    import rtc_pkg::*;
#(
    parameter int unsigned REFRESH_CYCLES = 1_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_req,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_ack,
    output logic       bus_start,
    output logic       bus_rw,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    input  logic [7:0] bus_rdata,
    input  logic       bus_listo,
    output logic       init_done,
    output logic [7:0] t_seg,
    output logic [7:0] t_min,
    output logic [7:0] t_hora,
    output logic [7:0] t_dia,
    output logic [7:0] t_mes,
    output logic [7:0] t_anio,
    output logic       snap_valid,
    output logic       bus_err
);

    logic [2:0]      state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic            bus_start_q, bus_start_d;
    logic            bus_rw_q, bus_rw_d;
    logic [7:0]      bus_addr_q, bus_addr_d;
    logic [7:0]      bus_wdata_q, bus_wdata_d;
    logic            init_done_q, init_done_d;
    logic            snap_valid_q, snap_valid_d;
    logic [5:0][7:0] snap_q, snap_d;
    logic [4:0][7:0] stage_q, stage_d;
    logic            ref_hit, ref_clr, ref_en;
    logic            in_wait, timeout, done, ack;

    assign in_wait = is_wait(state_q);
    assign ref_en  = (state_q == S_IDLE);
    assign done    = bus_listo | timeout;

    rtc_tick_counter #(.LIMIT(REFRESH_CYCLES)) u_refresh (
        .clk   (clk),
        .reset (reset),
        .clr   (ref_clr),
        .en    (ref_en),
        .hit   (ref_hit)
    );

`ifdef RTC_SEQ_TIMEOUT_EN
    logic to_hit;
    logic bus_err_q, bus_err_d;

    // Cleared in every non-wait cycle, so each transaction gets a fresh budget.
    rtc_tick_counter #(.LIMIT(TIMEOUT_CYCLES)) u_wait (
        .clk   (clk),
        .reset (reset),
        .clr   (!in_wait),
        .en    (in_wait),
        .hit   (to_hit)
    );

    assign timeout   = in_wait & to_hit & ~bus_listo;
    assign bus_err_d = bus_err_q | timeout;
    assign bus_err   = bus_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= bus_err_d;
        end
    end
`else
    assign timeout = 1'b0;
    assign bus_err = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        bus_start_d  = 1'b0;
        bus_rw_d     = bus_rw_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        init_done_d  = init_done_q;
        snap_valid_d = 1'b0;
        snap_d       = snap_q;
        stage_d      = stage_q;
        ref_clr      = 1'b0;
        ack          = 1'b0;
        case (state_q)
            S_INIT: begin
                bus_start_d = 1'b1;
                bus_rw_d    = 1'b0;
                bus_addr_d  = INIT_TBL[idx_q[0]].addr;
                bus_wdata_d = INIT_TBL[idx_q[0]].data;
                state_d     = S_INIT_WAIT;
            end
            S_INIT_WAIT: begin
                if (done) begin
                    if (idx_q == INIT_LAST) begin
                        init_done_d = 1'b1;
                        idx_d       = '0;
                        state_d     = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_INIT;
                    end
                end
            end
            S_IDLE: begin
                // On a tie the write goes first; the saturated counter
                // then starts the sweep on the next idle cycle.
                if (wr_req) begin
                    state_d = S_WR;
                end else if (ref_hit) begin
                    ref_clr = 1'b1;
                    idx_d   = '0;
                    state_d = S_RD;
                end
            end
            S_WR: begin
                bus_start_d = 1'b1;
                bus_rw_d    = 1'b0;
                bus_addr_d  = wr_addr;
                bus_wdata_d = wr_data;
                state_d     = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (done) begin
                    ack     = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_RD: begin
                bus_start_d = 1'b1;
                bus_rw_d    = 1'b1;
                bus_addr_d  = TIME_ADDR[idx_q];
                state_d     = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (timeout) begin
                    state_d = S_IDLE;
                end else if (bus_listo) begin
                    if (idx_q == TIME_LAST) begin
                        snap_d       = {bus_rdata, stage_q};
                        snap_valid_d = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        stage_d[idx_q] = bus_rdata;
                        idx_d          = idx_q + 3'd1;
                        state_d        = S_RD;
                    end
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_INIT;
            idx_q        <= '0;
            bus_start_q  <= 1'b0;
            bus_rw_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            init_done_q  <= 1'b0;
            snap_valid_q <= 1'b0;
            snap_q       <= '0;
            stage_q      <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            bus_start_q  <= bus_start_d;
            bus_rw_q     <= bus_rw_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            init_done_q  <= init_done_d;
            snap_valid_q <= snap_valid_d;
            snap_q       <= snap_d;
            stage_q      <= stage_d;
        end
    end

    assign wr_ack     = ack & ~reset;
    assign bus_start  = bus_start_q;
    assign bus_rw     = bus_rw_q;
    assign bus_addr   = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;
    assign init_done  = init_done_q;
    assign snap_valid = snap_valid_q;
    assign t_seg      = snap_q[0];
    assign t_min      = snap_q[1];
    assign t_hora     = snap_q[2];
    assign t_dia      = snap_q[3];
    assign t_mes      = snap_q[4];
    assign t_anio     = snap_q[5];

endmodule

// File: tb/tb_rtc_access_sequencer.sv
// Bench for rtc_access_sequencer: a timing-engine model answers each start
// after 10 cycles with addr+1; expected transactions are queued and popped.
module tb_rtc_access_sequencer;

    typedef struct {
        logic       rw;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] t_exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_req = 1'b0;
    logic [7:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic [7:0] bus_rdata = '0;
    logic       bus_listo = 1'b0;
    logic       wr_ack, bus_start, bus_rw, init_done, snap_valid, bus_err;
    logic [7:0] bus_addr, bus_wdata;
    logic [7:0] t_seg, t_min, t_hora, t_dia, t_mes, t_anio;

    int         checks = 0;
    int         failures = 0;
    vec_t       tbl[8];
    vec_t       exp_q[$];
    int         cyc = 0;
    bit         busy = 0;
    int         cnt = 0;
    logic       cur_rw = 1'b0;
    logic [7:0] cur_addr = '0;
    bit         drop_en = 0;
    int         fire26_cyc = -100;
    int         snap_cnt = 0;
    int         ack_cnt = 0;
    int         base_snaps;
    logic [47:0] prev_t = '0;

    rtc_access_sequencer #(
        .REFRESH_CYCLES (20),
        .TIMEOUT_CYCLES (15)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .bus_start  (bus_start),
        .bus_rw     (bus_rw),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_listo  (bus_listo),
        .init_done  (init_done),
        .t_seg      (t_seg),
        .t_min      (t_min),
        .t_hora     (t_hora),
        .t_dia      (t_dia),
        .t_mes      (t_mes),
        .t_anio     (t_anio),
        .snap_valid (snap_valid),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    function automatic logic [47:0] t_all();
        return {t_anio, t_mes, t_dia, t_hora, t_min, t_seg};
    endfunction

    function automatic logic [21:0] ctrl_all();
        return {wr_ack, bus_start, bus_rw, bus_addr, bus_wdata,
                init_done, snap_valid, bus_err};
    endfunction

    function automatic logic [7:0] t_val(input int i);
        case (i)
            0:       return t_seg;
            1:       return t_min;
            2:       return t_hora;
            3:       return t_dia;
            4:       return t_mes;
            default: return t_anio;
        endcase
    endfunction

    function automatic bit hit_sig(input int w, input logic [7:0] a);
        case (w)
            0:       return init_done;
            1:       return snap_valid;
            2:       return wr_ack;
            3:       return bus_err;
            default: return bus_start && bus_rw && (bus_addr == a);
        endcase
    endfunction

    task automatic wait_for(input string nm, input int w,
                            input logic [7:0] a, input int max);
        bit ok;
        ok = 0;
        for (int i = 0; i < max && !ok; i++) begin
            @(negedge clk);
            ok = hit_sig(w, a);
        end
        chk(nm, ok, 1);
    endtask

    task automatic push_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) exp_q.push_back(tbl[i]);
    endtask

    task automatic check_snap(input string nm);
        for (int i = 0; i < 6; i++) chk(nm, t_val(i), tbl[i+2].t_exp);
    endtask

    // Timing-engine model plus scoreboard pop on every bus_start.
    always @(posedge clk) begin
        vec_t e;
        cyc++;
        #1;
        bus_listo = 1'b0;
        bus_rdata = 8'h00;
        if (reset) begin
            busy = 0;
        end else begin
            if (busy) begin
                if (cnt == 1) begin
                    busy = 0;
                    if (!(drop_en && cur_rw && cur_addr == 8'h23)) begin
                        bus_listo = 1'b1;
                        bus_rdata = cur_addr + 8'h01;
                        chk("addr_stable", bus_addr, cur_addr);
                        if (cur_rw && cur_addr == 8'h26) fire26_cyc = cyc;
                    end
                end else begin
                    cnt--;
                end
            end
            if (bus_start) begin
                chk("start_overlap", busy, 0);
                chk("rd_before_init", bus_rw & ~init_done, 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_txn", {bus_rw, bus_addr}, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("txn_rw", bus_rw, e.rw);
                    chk("txn_addr", bus_addr, e.addr);
                    if (!e.rw) chk("txn_wdata", bus_wdata, e.wdata);
                end
                busy     = 1;
                cnt      = 10;
                cur_rw   = bus_rw;
                cur_addr = bus_addr;
            end
        end
    end

    always @(negedge clk) begin
        if (wr_ack) ack_cnt++;
        if (snap_valid) begin
            snap_cnt++;
            chk("snap_lag", cyc - fire26_cyc, 1);
        end
        if (!reset && !snap_valid && t_all() !== prev_t)
            chk("t_unsnapped_change", t_all(), prev_t);
        prev_t = t_all();
    end

    initial begin
        tbl[0] = '{1'b0, 8'h02, 8'h10, 8'h00};
        tbl[1] = '{1'b0, 8'h02, 8'h00, 8'h00};
        tbl[2] = '{1'b1, 8'h21, 8'h00, 8'h22};
        tbl[3] = '{1'b1, 8'h22, 8'h00, 8'h23};
        tbl[4] = '{1'b1, 8'h23, 8'h00, 8'h24};
        tbl[5] = '{1'b1, 8'h24, 8'h00, 8'h25};
        tbl[6] = '{1'b1, 8'h25, 8'h00, 8'h26};
        tbl[7] = '{1'b1, 8'h26, 8'h00, 8'h27};

        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", ctrl_all(), 0);
        chk("rst_t", t_all(), 0);
        push_range(0, 7);
        reset = 1'b0;

        wait_for("init_done", 0, 8'h00, 100);
        wait_for("snap1", 1, 8'h00, 300);
        check_snap("snap1_t");
        @(negedge clk);
        chk("snap_pulse_width", snap_valid, 0);

        // User write raised during the 3rd read waits for the sweep.
        push_range(2, 7);
        exp_q.push_back('{1'b0, 8'h21, 8'h45, 8'h00});
        wait_for("rd3_start", 4, 8'h23, 300);
        wr_addr = 8'h21;
        wr_data = 8'h45;
        wr_req  = 1'b1;
        wait_for("ack1", 2, 8'h00, 300);
        wr_req = 1'b0;
        @(posedge clk);
        #3;
        chk("ack_cnt1", ack_cnt, 1);
        chk("snap_cnt2", snap_cnt, 2);

        // Write request lands exactly on the refresh expiry cycle.
        push_range(2, 7);
        wait_for("snap3", 1, 8'h00, 300);
        exp_q.push_back('{1'b0, 8'h22, 8'h99, 8'h00});
        push_range(2, 7);
        repeat (19) @(negedge clk);
        wr_addr = 8'h22;
        wr_data = 8'h99;
        wr_req  = 1'b1;
        wait_for("ack2", 2, 8'h00, 50);
        wr_req = 1'b0;

        // Reset in the middle of the sweep's second read.
        wait_for("rd2_start", 4, 8'h22, 100);
        repeat (3) @(negedge clk);
        exp_q.delete();
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_ctrl", ctrl_all(), 0);
        chk("midrst_t", t_all(), 0);
        @(negedge clk);
        reset = 1'b0;
        push_range(0, 7);
        wait_for("init_done2", 0, 8'h00, 100);
        chk("post_rst_t", t_all(), 0);
        wait_for("snap4", 1, 8'h00, 300);
        check_snap("snap4_t");

`ifdef RTC_SEQ_TIMEOUT_EN
        drop_en = 1;
        push_range(2, 4);
        @(posedge clk);
        #3;
        base_snaps = snap_cnt;
        wait_for("bus_err", 3, 8'h00, 300);
        drop_en = 0;
        push_range(2, 7);
        @(posedge clk);
        #3;
        chk("to_no_snap", snap_cnt, base_snaps);
        check_snap("to_t_kept");
        wait_for("snap5", 1, 8'h00, 300);
        check_snap("snap5_t");
        chk("err_sticky", bus_err, 1);
`else
        base_snaps = snap_cnt;
        chk("bus_err_tied", bus_err, 0);
`endif

        @(posedge clk);
        #3;
        chk("ack_total", ack_cnt, 2);
        chk("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
